ps2_display_ctrl: RTL and testbench
===================================

// Module: ps2_display_ctrl
// PURPOSE
//  Sequences the shared PS/2-scancode-to-seven-segment decoder for a multi-digit display.
//  - Consumes scancode bytes from the PS/2 receiver and filters out break and extended sequences.
//  - Keeps a scrolling buffer of accepted make codes, newest at digit 0.
//  - Time-multiplexes the buffer onto one decoder instance and drives the digit enables.
// PARAMETERS
//  NUM_DIGITS  4      number of display digits / buffer entries (2..8)
//  SCAN_DIV    50000  clk cycles per digit slot in the multiplex scan (>=2)
// PORTS
//  clk         in   1              system clock, all logic on rising edge
//  rst_n       in   1              asynchronous active-low reset
//  code_valid  in   1              one-cycle strobe: code holds a new received byte
//  code        in   8              PS/2 scancode byte
//  dec_code    out  8              scancode of the digit being scanned, to decoder input
//  dig_en_n    out  NUM_DIGITS     active-low one-hot digit enable, aligned with dec_code
//  buf_flat    out  8*NUM_DIGITS   buffer contents, entry i at [8*i+7:8*i]
//  char_count  out  $clog2(NUM_DIGITS+1)  valid characters in buffer, 0..NUM_DIGITS
//  key_event   out  1              one-cycle pulse when a make code is pushed
// BEHAVIOUR
//  Reset state (async, rst_n=0):
//  - All buffer entries are 8'hFF (blank code; the decoder shows nothing).
//  - FSM=IDLE, scan_idx=0, scan counter=0, char_count=0, key_event=0.
//  - dig_en_n = ~1 (digit 0 enabled); dec_code=8'hFF.
//  FSM (advances only on code_valid; no change otherwise):
//  - IDLE:
//    - 8'hF0 -> BREAK.
//    - 8'hE0 -> EXT.
//    - 8'h76 (Esc): all entries <= FF, count <= 0.
//    - 8'h66 (Bksp): buf[i] <= buf[i+1], buf[N-1] <= FF, count decrements, floored at 0.
//    - 8'h00 / 8'hFF (keyboard error codes): ignored.
//    - Any other byte is a push: buf[0] <= code, buf[i+1] <= buf[i], oldest entry dropped.
//      count increments and saturates at NUM_DIGITS; key_event=1 on the next cycle.
//  - BREAK: any byte is consumed (released key), no buffer change -> IDLE.
//  - EXT: 8'hF0 -> EXT_BREAK; any other byte is consumed -> IDLE.
//  - EXT_BREAK: any byte is consumed -> IDLE.
//  Typematic repeats: repeated make codes push again each time.
//  Esc and Bksp act only in IDLE; their break codes are swallowed through BREAK.
//  Buffer/count update on the clk edge where code_valid=1; buf_flat reflects it next cycle.
//  Scan:
//  - The counter counts 0..SCAN_DIV-1. On wrap, scan_idx advances, NUM_DIGITS-1 wraps to 0.
//  - dig_en_n is registered from the next scan_idx.
//  - dec_code = buf[scan_idx] is combinational from registers, so it is always aligned with
//    dig_en_n and shows a buffer write one cycle after the edge.
//  - Scan runs independently of code_valid; simultaneous events need no priority.
//  Reset mid-sequence (e.g. in BREAK) returns to IDLE; the next byte is treated as a fresh code.
//  code_valid back-to-back on consecutive cycles is supported, one byte per cycle.
// TESTING
//  1 Reset, SCAN_DIV=4:
//    -> dig_en_n cycles 1110,1101,1011,0111 every 4 clk; dec_code=FF in every slot.
//  2 Bytes 1C,F0,1C,32,F0,32:
//    -> buf[0]=32, buf[1]=1C, rest FF; count=2; exactly two key_event pulses.
//  3 Push 16,1E,26,25,2E (N=4):
//    -> buf[3:0]=1E,26,25,2E; count stays 4; 16 dropped.
//  4 E0,75,E0,F0,75 then 45:
//    -> only 45 is pushed; FSM back in IDLE after each sequence.
//  5 From test 2 send 66,F0,66 -> buf[0]=1C, count=1; then 76,F0,76 -> all FF, count=0.
//  6 Assert rst_n=0 while in BREAK, release, send 1C:
//    -> 1C pushed, count=1; outputs match the reset values during reset.

Source files
------------

// File: rtl/ps2_display_ctrl.sv
// Purpose : filters PS/2 scancodes into a scrolling make-code buffer and time-multiplexes it onto one decoder.
// Latency : buffer/count update on the edge where code_valid=1; key_event and buf_flat follow one cycle later.
// Backpressure: none; one byte per cycle accepted unconditionally, scan runs free of input traffic.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   code_valid   one-cycle strobe qualifying code
//   code         received PS/2 byte
//   dec_code     buffer entry of the digit currently enabled, to the shared decoder
//   dig_en_n     active-low one-hot digit enable, aligned with dec_code
//   buf_flat     buffer entry i at [8*i+7:8*i], entry 0 is the newest
//   char_count   number of valid characters held (0..NUM_DIGITS)
//   key_event    one-cycle pulse after a make code is pushed
module ps2_display_ctrl #(
    parameter int  NUM_DIGITS = 4,
    parameter int  SCAN_DIV   = 50000,
    localparam int CW         = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    code_valid,
    input  logic [7:0]              code,
    output logic [7:0]              dec_code,
    output logic [NUM_DIGITS-1:0]   dig_en_n,
    output logic [8*NUM_DIGITS-1:0] buf_flat,
    output logic [CW-1:0]           char_count,
    output logic                    key_event
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(SCAN_DIV);

    localparam logic [7:0] BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } state_t;

    state_t        state, state_next;
    logic [7:0]    buf_q    [NUM_DIGITS];
    logic [7:0]    buf_next [NUM_DIGITS];
    logic [CW-1:0] count_next;
    logic          push;

    logic [SW-1:0] scan_cnt, scan_cnt_next;
    logic [IW-1:0] scan_idx, scan_idx_next;

    // Scancode sequencing: break (F0 xx) and extended (E0 xx / E0 F0 xx)
    // sequences are swallowed whole; only plain make codes reach the buffer.
    always_comb begin
        state_next = state;
        count_next = char_count;
        push       = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) buf_next[i] = buf_q[i];

        if (code_valid) begin
            unique case (state)
                IDLE: begin
                    case (code)
                        8'hF0: state_next = BREAK;
                        8'hE0: state_next = EXT;
                        8'h76: begin
                            for (int i = 0; i < NUM_DIGITS; i++) buf_next[i] = BLANK;
                            count_next = '0;
                        end
                        8'h66: begin
                            for (int i = 0; i < NUM_DIGITS - 1; i++) buf_next[i] = buf_q[i+1];
                            buf_next[NUM_DIGITS-1] = BLANK;
                            if (char_count != '0) count_next = char_count - CW'(1);
                        end
                        8'h00, 8'hFF: ;  // keyboard error codes
                        default: begin
                            push        = 1'b1;
                            buf_next[0] = code;
                            for (int i = 1; i < NUM_DIGITS; i++) buf_next[i] = buf_q[i-1];
                            if (char_count != CW'(NUM_DIGITS)) count_next = char_count + CW'(1);
                        end
                    endcase
                end
                BREAK:     state_next = IDLE;
                EXT:       state_next = (code == 8'hF0) ? EXT_BREAK : IDLE;
                EXT_BREAK: state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            char_count <= '0;
            key_event  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= BLANK;
        end else begin
            state      <= state_next;
            char_count <= count_next;
            key_event  <= push;
            for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= buf_next[i];
        end
    end

    // Digit scan: each slot lasts SCAN_DIV cycles.
    always_comb begin
        scan_cnt_next = scan_cnt + SW'(1);
        scan_idx_next = scan_idx;
        if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt_next = '0;
            scan_idx_next = (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
        end
    end

    // dig_en_n is registered from the next index so it changes on the same
    // edge as scan_idx and stays aligned with the combinational dec_code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            dig_en_n <= ~NUM_DIGITS'(1);
        end else begin
            scan_cnt <= scan_cnt_next;
            scan_idx <= scan_idx_next;
            dig_en_n <= ~(NUM_DIGITS'(1) << scan_idx_next);
        end
    end

    assign dec_code = buf_q[scan_idx];

    always_comb begin
        buf_flat = '0;
        for (int i = 0; i < NUM_DIGITS; i++) buf_flat[8*i +: 8] = buf_q[i];
    end

endmodule

// File: tb/tb_ps2_display_ctrl.sv
module tb_ps2_display_ctrl;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          code_valid;
    logic [7:0]    code;
    logic [7:0]    dec_code;
    logic [N-1:0]  dig_en_n;
    logic [8*N-1:0] buf_flat;
    logic [2:0]    char_count;
    logic          key_event;

    int passed = 0;
    int total  = 0;
    int kev_cnt = 0;
    logic [7:0] exp_q[$];

    ps2_display_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code       (code),
        .dec_code   (dec_code),
        .dig_en_n   (dig_en_n),
        .buf_flat   (buf_flat),
        .char_count (char_count),
        .key_event  (key_event)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every key_event pulse must match the oldest pending make code.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_event === 1'b1) begin
            kev_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_key_event", 32'(buf_flat[7:0]), 32'h1FF);
            end else begin
                check("key_event_buf0", 32'(buf_flat[7:0]), 32'(exp_q.pop_front()));
            end
        end
    end

    // Called at a negedge; drives one byte for one cycle. Back-to-back calls
    // give consecutive-cycle strobes.
    task automatic send(input logic [7:0] b, input bit make);
        code_valid = 1'b1;
        code       = b;
        if (make) exp_q.push_back(b);
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp_flat, input int exp_cnt);
        check({tag, "_buf"}, buf_flat, exp_flat);
        check({tag, "_count"}, 32'(char_count), 32'(exp_cnt));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Over one full scan, dec_code must equal the entry of the enabled digit.
    task automatic check_scan(input string tag, input logic [31:0] exp_flat);
        int idx;
        for (int c = 0; c < N * DIV; c += DIV) begin
            repeat (DIV) @(negedge clk);
            idx = 0;
            for (int i = 0; i < N; i++) if (!dig_en_n[i]) idx = i;
            check({tag, "_onehot"}, 32'($countones(~dig_en_n)), 32'd1);
            check({tag, "_dec"}, 32'(dec_code), 32'(exp_flat[8*idx +: 8]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dig_en_n"}, 32'(dig_en_n), 32'hE);
        check({tag, "_dec_code"}, 32'(dec_code), 32'hFF);
        check({tag, "_buf"}, buf_flat, 32'hFFFF_FFFF);
        check({tag, "_count"}, 32'(char_count), 32'd0);
        check({tag, "_key_event"}, 32'(key_event), 32'd0);
    endtask

    initial begin
        logic [N-1:0] exp_en;
        int k0;

        // 1: reset values and free-running scan
        rst_n = 1'b0; code_valid = 1'b0; code = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst1");
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_en = '1;
            exp_en[(k / DIV) % N] = 1'b0;
            check($sformatf("scan_en_k%0d", k), 32'(dig_en_n), 32'(exp_en));
            check($sformatf("scan_dec_k%0d", k), 32'(dec_code), 32'hFF);
        end

        // 2: make/break filtering, two pushes
        k0 = kev_cnt;
        send(8'h1C, 1); send(8'hF0, 0); send(8'h1C, 0);
        send(8'h32, 1); send(8'hF0, 0); send(8'h32, 0);
        @(negedge clk);
        check_state("t2", 32'hFFFF_1C32, 2);
        check("t2_kev_pulses", 32'(kev_cnt - k0), 32'd2);
        check_scan("t2_scan", 32'hFFFF_1C32);

        // 5: backspace then escape, with their break codes swallowed
        send(8'h66, 0); send(8'hF0, 0); send(8'h66, 0);
        @(negedge clk);
        check_state("t5_bksp", 32'hFFFF_FF1C, 1);
        send(8'h76, 0); send(8'hF0, 0); send(8'h76, 0);
        @(negedge clk);
        check_state("t5_esc", 32'hFFFF_FFFF, 0);
        send(8'h66, 0);
        @(negedge clk);
        check_state("t5_bksp_floor", 32'hFFFF_FFFF, 0);
        send(8'h00, 0); send(8'hFF, 0);
        @(negedge clk);
        check_state("t5_errcodes", 32'hFFFF_FFFF, 0);

        // 3: overflow drops the oldest, count saturates
        k0 = kev_cnt;
        send(8'h16, 1); send(8'h1E, 1); send(8'h26, 1); send(8'h25, 1); send(8'h2E, 1);
        @(negedge clk);
        check_state("t3", 32'h1E26_252E, 4);
        check("t3_kev_pulses", 32'(kev_cnt - k0), 32'd5);
        check_scan("t3_scan", 32'h1E26_252E);

        // 4: extended make and extended break swallowed, then plain make
        k0 = kev_cnt;
        send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
        send(8'h45, 1);
        @(negedge clk);
        check_state("t4", 32'h2625_2E45, 4);
        check("t4_kev_pulses", 32'(kev_cnt - k0), 32'd1);

        // 6: reset while in BREAK, next byte is a fresh make code
        send(8'hF0, 0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("rst6");
        @(negedge clk);
        check_reset_outputs("rst6_held");
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h1C, 1);
        @(negedge clk);
        check_state("t6", 32'hFFFF_FF1C, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
